pipe_skid_stage: RTL

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline stage with registered in_ready and one-cycle latency.
// Optional saturating stall counter port enabled by PIPE_STAGE_STALL_CNT_EN.
module pipe_skid_stage #(
  parameter int unsigned       DATA_W  = 33,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              push, pop;

  // Handshakes use only flopped state, so in_ready has no path from out_ready.
  always_comb begin
    push = in_valid & in_ready_q;
    pop  = out_valid & out_ready;
  end

  // State and in_ready registers; in_ready is precomputed from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state decision: flush wins over any push or pop.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) state_d = S_ONE;
        end
        S_ONE: begin
          if (push && !pop)      state_d = S_TWO;
          else if (!push && pop) state_d = S_EMPTY;
        end
        S_TWO: begin
          if (pop) state_d = S_ONE;
        end
        default: state_d = S_EMPTY;
      endcase
    end
    in_ready_d = (state_d != S_TWO);
  end

  // Output decode from the current state.
  always_comb begin
    out_valid = (state_q != S_EMPTY);
    out_data  = out_valid ? main_q : NOP_VAL;
    in_ready  = in_ready_q;
  end

  // Payload steering: main always holds the oldest entry, skid the newer.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!flush) begin
      case (state_q)
        S_EMPTY: begin
          if (push) main_d = in_data;
        end
        S_ONE: begin
          if (push && pop) main_d = in_data;
          else if (push)   skid_d = in_data;
        end
        S_TWO: begin
          if (pop) main_d = skid_q;
        end
        default: ;
      endcase
    end
  end

  // Main payload register; cleared so nothing stale survives reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) main_q <= NOP_VAL;
    else     main_q <= main_d;
  end

  // Skid payload register; only observable in TWO, so it is not reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a valid entry is held back, saturating at all ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      stall_cnt_d = 16'h0000;
    end else if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'h0001;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= 16'h0000;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
